// File: rtl/seq_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_mult_pkg                                           |
// | Description : Shared types and constants for the seq_mult sequencer. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package seq_mult_pkg;

   // Largest supported digit count per operand
   localparam int MAX_N = 8;

   // Width of the digit-index selects driven into seq_mult
   localparam int IDX_W = $clog2(MAX_N);

   // Width of the column counter; columns run 0 .. 2*MAX_N-2
   localparam int COL_W = IDX_W + 1;

   // Operation sequence of the controller
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_MAC   = 3'd2,
      S_LAST  = 3'd3,
      S_CAPT  = 3'd4,
      S_DONE  = 3'd5
   } seq_state_e;

   // Smaller of two column-width indices
   function automatic logic [COL_W-1:0] min_idx(input logic [COL_W-1:0] a,
                                                input logic [COL_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_mult_ctrl_if                                       |
// | Description : Request / result handshake bundle of seq_mult_ctrl.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface seq_mult_ctrl_if #(
   parameter int W = 16
) ();

   logic           req_valid;
   logic           req_ready;
   logic [W-1:0]   req_a;
   logic [W-1:0]   req_b;
   logic           req_signed;
   logic           res_valid;
   logic           res_ready;
   logic [2*W-1:0] res_prod;

   // Controller side
   modport slave (
      input  req_valid, req_a, req_b, req_signed, res_ready,
      output req_ready, res_valid, res_prod
   );

   // Operand source / result consumer side
   modport master (
      output req_valid, req_a, req_b, req_signed, res_ready,
      input  req_ready, res_valid, res_prod
   );

endinterface
`default_nettype wire

// File: rtl/seq_mult_collect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_mult_collect                                       |
// | Description : Captures multiplier output digits into the product.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_mult_collect #(
   parameter int P = 2,
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           cap_req,
   input  logic [P-1:0]   digit,
   output logic [2*W-1:0] prod
);

   logic           r_cap_en;
   logic [2*W-1:0] r_prod;

   // A digit appears one cycle after its strobe, so the capture enable lags by one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap_en <= 1'b0;
      end else begin
         r_cap_en <= cap_req;
      end
   end

   // Product shift register: new digits enter at the top, first digit ends at the LSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod <= '0;
      end else if (clear) begin
         r_prod <= '0;
      end else if (r_cap_en) begin
         r_prod <= {digit, r_prod[2*W-1:P]};
      end
   end

   assign prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_mult_ctrl                                          |
// | Description : Sequencer and result collector for digit-serial        |
// |               multiplier seq_mult (product-scanning schedule).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int             P           = 2,
   parameter int             W           = 16,
   parameter logic [4*P-1:0] SIGNED_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_mult_ctrl_if.slave   bus,
   output logic             mul_start,
   output logic [W-1:0]     mul_a,
   output logic [W-1:0]     mul_b,
   output logic [IDX_W-1:0] mul_sel_a,
   output logic [IDX_W-1:0] mul_sel_b,
   output logic             mul_count_last2,
   output logic             mul_last_out,
   output logic             mul_invert_first,
   output logic             mul_invert_second,
   output logic [4*P-1:0]   mul_init_sum,
   output logic [1:0]       mul_count_shift_in,
   input  logic [P-1:0]     mul_p
);

   localparam int N = W / P;
   localparam logic [COL_W-1:0] c_n_m1   = COL_W'(N - 1);
   localparam logic [COL_W-1:0] c_k_last = COL_W'(2 * N - 2);

   seq_state_e       r_state;
   seq_state_e       w_state_nxt;
   logic [COL_W-1:0] r_k;
   logic [COL_W-1:0] w_k_nxt;
   logic [IDX_W-1:0] r_i;
   logic [IDX_W-1:0] w_i_nxt;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic             r_signed;

   logic             w_accept;
   logic             w_req_ready;
   logic             w_res_valid;
   logic [COL_W-1:0] w_i_ext;
   logic [COL_W-1:0] w_i_last;
   logic [COL_W-1:0] w_j;
   logic [COL_W-1:0] w_k_inc;
   logic [IDX_W-1:0] w_i_first;
   logic             w_col_end;
   logic [2*W-1:0]   w_prod;

   // Column geometry: i walks max(0,k-N+1) .. min(k,N-1), j = k - i
   assign w_i_ext   = {{(COL_W-IDX_W){1'b0}}, r_i};
   assign w_i_last  = min_idx(r_k, c_n_m1);
   assign w_j       = r_k - w_i_ext;
   assign w_col_end = (w_i_ext == w_i_last);
   assign w_k_inc   = r_k + 1'b1;
   assign w_i_first = (w_k_inc > c_n_m1) ? IDX_W'(w_k_inc - c_n_m1) : '0;

   assign w_accept  = (r_state == S_IDLE) && bus.req_valid;

   // Next-state, schedule counters and all decoded strobes
   always_comb begin
      w_state_nxt       = r_state;
      w_k_nxt           = r_k;
      w_i_nxt           = r_i;
      w_req_ready       = 1'b0;
      w_res_valid       = 1'b0;
      mul_start         = 1'b0;
      mul_sel_a         = '0;
      mul_sel_b         = '0;
      mul_count_last2   = 1'b0;
      mul_last_out      = 1'b0;
      mul_invert_first  = 1'b0;
      mul_invert_second = 1'b0;
      mul_init_sum      = '0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            mul_start    = 1'b1;
            mul_init_sum = r_signed ? SIGNED_INIT : '0;
            w_k_nxt      = '0;
            w_i_nxt      = '0;
            w_state_nxt  = S_MAC;
         end
         S_MAC: begin
            mul_sel_a         = r_i;
            mul_sel_b         = w_j[IDX_W-1:0];
            mul_invert_first  = r_signed & (w_i_ext == c_n_m1);
            mul_invert_second = r_signed & (w_j == c_n_m1);
            if (w_col_end) begin
               mul_count_last2 = 1'b1;
               if (r_k == c_k_last) begin
                  w_state_nxt = S_LAST;
               end else begin
                  w_k_nxt = w_k_inc;
                  w_i_nxt = w_i_first;
               end
            end else begin
               w_i_nxt = r_i + 1'b1;
            end
         end
         S_LAST: begin
            mul_last_out = 1'b1;
            w_state_nxt  = S_CAPT;
         end
         S_CAPT: begin
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_res_valid = 1'b1;
            if (bus.res_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register and column/row counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_k     <= '0;
         r_i     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
         r_i     <= w_i_nxt;
      end
   end

   // Operand latch: held from acceptance until the next acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
      end else if (w_accept) begin
         r_a      <= bus.req_a;
         r_b      <= bus.req_b;
         r_signed <= bus.req_signed;
      end
   end

   seq_mult_collect #(
      .P (P),
      .W (W)
   ) u_collect (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_accept),
      .cap_req (mul_count_last2 | mul_last_out),
      .digit   (mul_p),
      .prod    (w_prod)
   );

   assign mul_a              = r_a;
   assign mul_b              = r_b;
   assign mul_count_shift_in = 2'b00;
   assign bus.req_ready      = w_req_ready;
   assign bus.res_valid      = w_res_valid;
   assign bus.res_prod       = w_prod;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seq_mult_ctrl                                       |
// | Description : Directed self-checking bench for seq_mult_ctrl with a  |
// |               behavioural product-scanning multiplier stand-in.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seq_mult_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   seq_mult_ctrl_if #(.W(16)) b16 ();
   seq_mult_ctrl_if #(.W(4))  b4 ();

   logic        m16_start, m16_cl, m16_lo, m16_i1, m16_i2;
   logic [15:0] m16_a, m16_b;
   logic [2:0]  m16_sa, m16_sb;
   logic [7:0]  m16_init;
   logic [1:0]  m16_csi, m16_p;

   logic        m4_start, m4_cl, m4_lo, m4_i1, m4_i2;
   logic [3:0]  m4_a, m4_b;
   logic [2:0]  m4_sa, m4_sb;
   logic [7:0]  m4_init;
   logic [1:0]  m4_csi, m4_p;

   seq_mult_ctrl #(.P(2), .W(16), .SIGNED_INIT(8'h00)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .bus(b16),
      .mul_start(m16_start), .mul_a(m16_a), .mul_b(m16_b),
      .mul_sel_a(m16_sa), .mul_sel_b(m16_sb),
      .mul_count_last2(m16_cl), .mul_last_out(m16_lo),
      .mul_invert_first(m16_i1), .mul_invert_second(m16_i2),
      .mul_init_sum(m16_init), .mul_count_shift_in(m16_csi), .mul_p(m16_p)
   );

   seq_mult_ctrl #(.P(2), .W(4), .SIGNED_INIT(8'h00)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .bus(b4),
      .mul_start(m4_start), .mul_a(m4_a), .mul_b(m4_b),
      .mul_sel_a(m4_sa), .mul_sel_b(m4_sb),
      .mul_count_last2(m4_cl), .mul_last_out(m4_lo),
      .mul_invert_first(m4_i1), .mul_invert_second(m4_i2),
      .mul_init_sum(m4_init), .mul_count_shift_in(m4_csi), .mul_p(m4_p)
   );

   // Digit value of an operand; the MSB digit is two's-complement when flagged
   function automatic longint dig(input logic [15:0] v, input logic [2:0] idx, input logic sgn);
      longint d;
      d = longint'((v >> (2 * idx)) & 16'h0003);
      if (sgn && d >= 2) d = d - 4;
      return d;
   endfunction

   // Multiplier stand-in: column accumulator, digit out one cycle after each strobe
   longint m16_acc, m16_sum, m4_acc, m4_sum;
   logic   m16_act, m4_act;

   always_comb m16_sum = m16_acc + dig(m16_a, m16_sa, m16_i1) * dig(m16_b, m16_sb, m16_i2);
   always_comb m4_sum  = m4_acc + dig({12'h000, m4_a}, m4_sa, m4_i1) * dig({12'h000, m4_b}, m4_sb, m4_i2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m16_acc <= 0; m16_act <= 1'b0; m16_p <= 2'b00;
      end else if (m16_start) begin
         m16_acc <= longint'(m16_init); m16_act <= 1'b1;
      end else if (m16_lo) begin
         m16_p <= m16_acc[1:0]; m16_act <= 1'b0;
      end else if (m16_act) begin
         if (m16_cl) begin
            m16_p <= m16_sum[1:0]; m16_acc <= m16_sum >>> 2;
         end else begin
            m16_acc <= m16_sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m4_acc <= 0; m4_act <= 1'b0; m4_p <= 2'b00;
      end else if (m4_start) begin
         m4_acc <= longint'(m4_init); m4_act <= 1'b1;
      end else if (m4_lo) begin
         m4_p <= m4_acc[1:0]; m4_act <= 1'b0;
      end else if (m4_act) begin
         if (m4_cl) begin
            m4_p <= m4_sum[1:0]; m4_acc <= m4_sum >>> 2;
         end else begin
            m4_acc <= m4_sum;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request in the current cycle and move to its START cycle
   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s, input string tag);
      b16.req_a = a; b16.req_b = b; b16.req_signed = s; b16.req_valid = 1'b1;
      check({tag, "_ready"}, 64'(b16.req_ready), 64'd1);
      tick();
      b16.req_valid = 1'b0;
      check({tag, "_start"}, 64'(m16_start), 64'd1);
      check({tag, "_init"}, 64'(m16_init), 64'd0);
   endtask

   // From START, run to DONE while counting strobes and checking the invert flags
   task automatic wait16(input logic s, input string tag);
      int lat = 1;
      int n_i1 = 0, n_i2 = 0, n_bad = 0, n_cl = 0, n_lo = 0;
      while (lat < 200) begin
         if (b16.res_valid) break;
         if (m16_i1) n_i1++;
         if (m16_i2) n_i2++;
         if (m16_i1 !== (s && m16_sa == 3'd7)) n_bad++;
         if (m16_i2 !== (s && m16_sb == 3'd7)) n_bad++;
         if (m16_cl) n_cl++;
         if (m16_lo) n_lo++;
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'd68);
      check({tag, "_inv1_cnt"}, 64'(n_i1), s ? 64'd8 : 64'd0);
      check({tag, "_inv2_cnt"}, 64'(n_i2), s ? 64'd8 : 64'd0);
      check({tag, "_inv_pos"}, 64'(n_bad), 64'd0);
      check({tag, "_colend_cnt"}, 64'(n_cl), 64'd15);
      check({tag, "_flush_cnt"}, 64'(n_lo), 64'd1);
   endtask

   // One-cycle result acceptance, then confirm return to IDLE
   task automatic pop16(input string tag);
      b16.res_ready = 1'b1;
      tick();
      b16.res_ready = 1'b0;
      check({tag, "_idle"}, 64'(b16.req_ready), 64'd1);
   endtask

   logic [2:0] exp_sa[4] = '{3'd0, 3'd0, 3'd1, 3'd1};
   logic [2:0] exp_sb[4] = '{3'd0, 3'd1, 3'd0, 3'd1};
   logic       exp_cl[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      int n_bad;
      b16.req_valid = 1'b0; b16.req_a = '0; b16.req_b = '0; b16.req_signed = 1'b0; b16.res_ready = 1'b0;
      b4.req_valid  = 1'b0; b4.req_a  = '0; b4.req_b  = '0; b4.req_signed  = 1'b0; b4.res_ready  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      check("rst_req_ready", 64'(b16.req_ready), 64'd1);
      check("rst_res_valid", 64'(b16.res_valid), 64'd0);
      check("rst_res_prod", 64'(b16.res_prod), 64'd0);
      check("rst_mul_ab", 64'({m16_a, m16_b}), 64'd0);
      check("rst_strobes", 64'({m16_start, m16_cl, m16_lo, m16_i1, m16_i2, m16_sa, m16_sb, m16_init, m16_csi}), 64'd0);
      check("rst_req_ready_n2", 64'(b4.req_ready), 64'd1);
      rst_n = 1'b1;
      tick();

      // N=2: 3 x 2 unsigned, full schedule cycle by cycle
      b4.req_a = 4'd3; b4.req_b = 4'd2; b4.req_valid = 1'b1;
      check("n2_ready", 64'(b4.req_ready), 64'd1);
      tick();
      b4.req_valid = 1'b0;
      check("n2_start", 64'(m4_start), 64'd1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("n2_sel_c%0d", c), 64'({m4_sa, m4_sb}), 64'({exp_sa[c], exp_sb[c]}));
         check($sformatf("n2_colend_c%0d", c), 64'({m4_cl, m4_lo}), 64'({exp_cl[c], 1'b0}));
      end
      tick();
      check("n2_last", 64'({m4_cl, m4_lo}), 64'b01);
      tick();
      check("n2_capt_valid", 64'(b4.res_valid), 64'd0);
      tick();
      check("n2_done_valid", 64'(b4.res_valid), 64'd1);
      check("n2_prod", 64'(b4.res_prod), 64'h06);
      check("n2_quiet", 64'({m4_i1, m4_i2, m4_init, m4_csi}), 64'd0);
      b4.res_ready = 1'b1;
      tick();
      b4.res_ready = 1'b0;
      check("n2_idle", 64'(b4.req_ready), 64'd1);

      // N=8 unsigned full-scale
      issue16(16'hFFFF, 16'hFFFF, 1'b0, "uu");
      wait16(1'b0, "uu");
      check("uu_prod", 64'(b16.res_prod), 64'hFFFE0001);
      pop16("uu");

      // N=8 signed: -1 x 3
      issue16(16'hFFFF, 16'h0003, 1'b1, "ss");
      wait16(1'b1, "ss");
      check("ss_prod", 64'(b16.res_prod), 64'hFFFFFFFD);

      // Backpressure in DONE with a competing request
      b16.req_a = 16'h1111; b16.req_b = 16'h2222; b16.req_signed = 1'b0; b16.req_valid = 1'b1;
      n_bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (b16.res_valid !== 1'b1 || b16.res_prod !== 32'hFFFFFFFD || b16.req_ready !== 1'b0) n_bad++;
      end
      check("bp_stable", 64'(n_bad), 64'd0);
      check("bp_ops_held", 64'({m16_a, m16_b}), 64'hFFFF0003);
      b16.req_valid = 1'b0;
      pop16("bp");
      check("bp_valid_drop", 64'(b16.res_valid), 64'd0);

      // Back-to-back: second acceptance in the cycle after the result handshake
      issue16(16'd5, 16'd7, 1'b0, "b2b1");
      wait16(1'b0, "b2b1");
      check("b2b1_prod", 64'(b16.res_prod), 64'd35);
      b16.res_ready = 1'b1;
      b16.req_a = 16'd9; b16.req_b = 16'd9; b16.req_signed = 1'b0; b16.req_valid = 1'b1;
      tick();
      b16.res_ready = 1'b0;
      check("b2b_ready_next", 64'(b16.req_ready), 64'd1);
      check("b2b_valid_drop", 64'(b16.res_valid), 64'd0);
      tick();
      b16.req_valid = 1'b0;
      check("b2b2_start", 64'(m16_start), 64'd1);
      wait16(1'b0, "b2b2");
      check("b2b2_prod", 64'(b16.res_prod), 64'd81);
      pop16("b2b2");

      // Abort in the first cycle of column 5 (MAC cycle 16)
      issue16(16'hFFFF, 16'hFFFF, 1'b0, "ab");
      repeat (16) tick();
      check("ab_col5_sel", 64'({m16_sa, m16_sb}), 64'({3'd0, 3'd5}));
      rst_n = 1'b0;
      #1;
      check("ab_req_ready", 64'(b16.req_ready), 64'd1);
      check("ab_res_valid", 64'(b16.res_valid), 64'd0);
      check("ab_res_prod", 64'(b16.res_prod), 64'd0);
      check("ab_mul_ab", 64'({m16_a, m16_b}), 64'd0);
      check("ab_strobes", 64'({m16_start, m16_cl, m16_lo, m16_i1, m16_i2, m16_sa, m16_sb, m16_init}), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      issue16(16'h1234, 16'h0056, 1'b0, "post");
      wait16(1'b0, "post");
      check("post_prod", 64'(b16.res_prod), 64'h00061D78);
      pop16("post");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
